// File: rtl/mac_vec_accum_if.sv
// Operand/result bus of the vector MAC engine; master = producer/consumer side, slave = engine.
`timescale 1ns/1ps
interface mac_vec_accum_if #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int ACC_W  = 20,
    parameter int CNT_W  = 8
);
    // Both channels: a transfer happens on a rising edge where valid and ready are both 1;
    // the sender keeps valid and payload stable until then, ready never depends on the payload.
    logic                      in_valid;
    logic                      in_ready;
    logic                      in_last;
    logic [LANES*DATA_W-1:0]   ain;
    logic [LANES*DATA_W-1:0]   bin;
    logic                      out_valid;
    logic                      out_ready;
    logic [ACC_W-1:0]          sum;
    logic [CNT_W-1:0]          beats;
    logic                      ovf;

    modport master (
        output in_valid, in_last, ain, bin, out_ready,
        input  in_ready, out_valid, sum, beats, ovf
    );

    modport slave (
        input  in_valid, in_last, ain, bin, out_ready,
        output in_ready, out_valid, sum, beats, ovf
    );
endinterface

// File: rtl/mac_vec_accum.sv
// Multi-lane unsigned dot-product engine: products -> adder tree/accumulator -> result register.
// Optional saturation of the accumulator is compiled in with `define MAC_SAT_EN.
`timescale 1ns/1ps
module mac_vec_accum #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int ACC_W  = 20,
    parameter int CNT_W  = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clr,
    mac_vec_accum_if.slave     bus,
    output logic [1:0]         o_state
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int TREE_W = 2 * DATA_W + $clog2(LANES);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_HOLD} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_active;
    logic                w_accept;
    logic [PROD_W-1:0]   r_prod [LANES];
    logic                r_s1_v;
    logic                r_s1_last;
    logic                r_s1_first;
    logic [TREE_W-1:0]   w_tree;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    w_acc_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                r_s2_v;
    logic                r_s2_last;
    logic [ACC_W-1:0]    r_sum;
    logic [CNT_W-1:0]    r_beats;
    logic                r_out_valid;

    // in_ready stays low while reset is held and until the first edge after release.
    assign bus.in_ready  = r_active && (r_state == S_IDLE || r_state == S_ACCUM);
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.beats     = r_beats;
    assign o_state       = r_state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_active <= 1'b0;
        else          r_active <= 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)   r_state <= S_IDLE;
        else if (i_clr) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = bus.in_last ? S_DRAIN : S_ACCUM;
            S_ACCUM: if (w_accept && bus.in_last) w_next = S_DRAIN;
            S_DRAIN: if (r_s2_v && r_s2_last) w_next = S_HOLD;
            S_HOLD:  if (r_out_valid && bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_tree = '0;
        for (int i = 0; i < LANES; i++) w_tree = w_tree + TREE_W'(r_prod[i]);
    end

`ifdef MAC_SAT_EN
    logic               r_ovf_acc;
    logic               w_ovf_next;
    logic               r_ovf;
    logic [ACC_W:0]     w_sum_ext;

    // A carry out pins the accumulator at all-ones; further adds keep carrying or add zero.
    always_comb begin
        w_sum_ext  = {1'b0, r_acc} + (ACC_W + 1)'(w_tree);
        w_acc_next = r_acc;
        w_ovf_next = r_ovf_acc;
        if (r_s1_first) begin
            w_acc_next = ACC_W'(w_tree);
            w_ovf_next = 1'b0;
        end else if (w_sum_ext[ACC_W]) begin
            w_acc_next = '1;
            w_ovf_next = 1'b1;
        end else begin
            w_acc_next = w_sum_ext[ACC_W-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf_acc <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (i_clr) begin
            r_ovf_acc <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (r_s1_v)               r_ovf_acc <= w_ovf_next;
            if (r_s2_v && r_s2_last)  r_ovf     <= r_ovf_acc;
        end
    end

    assign bus.ovf = r_ovf;
`else
    always_comb begin
        w_acc_next = r_s1_first ? ACC_W'(w_tree) : r_acc + ACC_W'(w_tree);
    end

    assign bus.ovf = 1'b0;
`endif

    always_comb begin
        w_cnt_next = r_cnt;
        if (r_s1_first)        w_cnt_next = CNT_W'(1);
        else if (r_cnt != '1)  w_cnt_next = r_cnt + CNT_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < LANES; i++) r_prod[i] <= '0;
            r_s1_v      <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_first  <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_s2_v      <= 1'b0;
            r_s2_last   <= 1'b0;
            r_sum       <= '0;
            r_beats     <= '0;
            r_out_valid <= 1'b0;
        end else if (i_clr) begin
            for (int i = 0; i < LANES; i++) r_prod[i] <= '0;
            r_s1_v      <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_first  <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_s2_v      <= 1'b0;
            r_s2_last   <= 1'b0;
            r_sum       <= '0;
            r_beats     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                for (int i = 0; i < LANES; i++)
                    r_prod[i] <= PROD_W'(bus.ain[i*DATA_W +: DATA_W]) * PROD_W'(bus.bin[i*DATA_W +: DATA_W]);
            end
            r_s1_v     <= w_accept;
            r_s1_last  <= w_accept && bus.in_last;
            r_s1_first <= (r_state == S_IDLE);
            if (r_s1_v) begin
                r_acc <= w_acc_next;
                r_cnt <= w_cnt_next;
            end
            r_s2_v    <= r_s1_v;
            r_s2_last <= r_s1_v && r_s1_last;
            if (r_s2_v && r_s2_last) begin
                r_sum       <= r_acc;
                r_beats     <= r_cnt;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mac_vec_accum.sv
// Bench for mac_vec_accum: directed scenarios plus random vectors against a dot-product model.
`timescale 1ns/1ps
module tb_mac_vec_accum;
    localparam int DATA_W = 8;
    localparam int LANES  = 4;
    localparam int ACC_W  = 20;
    localparam int CNT_W  = 8;
    localparam int LW     = LANES * DATA_W;
    localparam int EXP_W  = 1 + CNT_W + ACC_W;
    localparam longint MAX_ACC = (64'd1 << ACC_W) - 1;
    localparam longint MAX_CNT = (64'd1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic [1:0] dbg_state;

    mac_vec_accum_if #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    mac_vec_accum #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (clr),
        .bus     (bus),
        .o_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int beat_edge = 0;
    logic bp_force = 1'b0;
    logic bp_val = 1'b0;
    logic prev_ov = 1'b0;
    logic [EXP_W-1:0] exp_q[$];
    int hs_q[$];
    logic [EXP_W-1:0] cmp_e;
    logic [ACC_W-1:0] last_sum = '0;
    logic [CNT_W-1:0] last_beats = '0;
    logic last_ovf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint dot(input logic [LW-1:0] a, input logic [LW-1:0] b);
        longint s = 0;
        for (int i = 0; i < LANES; i++)
            s += longint'(a[i*DATA_W +: DATA_W]) * longint'(b[i*DATA_W +: DATA_W]);
        return s;
    endfunction

    // Whole-vector view: the final sum is the exact dot product, reduced by wrap or clamp.
    function automatic logic [EXP_W-1:0] model(input longint total, input int n);
        logic [ACC_W-1:0] s;
        logic [CNT_W-1:0] b;
        logic o;
`ifdef MAC_SAT_EN
        o = (total > MAX_ACC);
        s = o ? ACC_W'(MAX_ACC) : ACC_W'(total);
`else
        o = 1'b0;
        s = ACC_W'(total);
`endif
        b = (longint'(n) > MAX_CNT) ? CNT_W'(MAX_CNT) : CNT_W'(n);
        return {o, b, s};
    endfunction

    task automatic gen_pair(input int kind, output logic [LW-1:0] a, output logic [LW-1:0] b);
        case (kind)
            1: begin a = 32'h01010101; b = 32'h01010101; end
            2: begin a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; end
            3: begin a = 32'h04030201; b = 32'h08070605; end
            4: begin a = 32'h01010101; b = 32'h02020202; end
            5: begin a = $urandom & 32'h0F0F0F0F; b = $urandom & 32'h0F0F0F0F; end
            default: begin a = $urandom; b = $urandom; end
        endcase
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send_beat(input logic [LW-1:0] a, input logic [LW-1:0] b, input logic last);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.ain = a;
        bus.bin = b;
        bus.in_last = last;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", bus.in_ready, 1'b1);
        beat_edge = cyc + 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last = 1'($urandom_range(0, 1));
        bus.ain = $urandom;
        bus.bin = $urandom;
    endtask

    task automatic send_vec(input int n, input int kind, input int gap_max);
        logic [LW-1:0] a;
        logic [LW-1:0] b;
        longint total = 0;
        for (int k = 0; k < n; k++) begin
            gen_pair(kind, a, b);
            send_beat(a, b, k == n - 1);
            total += dot(a, b);
            if (k < n - 1 && gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
        end
        exp_q.push_back(model(total, n));
        hs_q.push_back(beat_edge);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && t < 600) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0 || bus.out_valid) begin
            chk("drain_timeout", 64'(exp_q.size()), 0);
            exp_q.delete();
            hs_q.delete();
        end
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!bus.out_valid && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!bus.out_valid) chk("out_valid_timeout", bus.out_valid, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 1'b0);
        chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
        chk({tag, "_sum"}, bus.sum, 0);
        chk({tag, "_beats"}, bus.beats, 0);
        chk({tag, "_ovf"}, bus.ovf, 1'b0);
    endtask

    task automatic pulse_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_reset_values(tag);
        exp_q.delete();
        hs_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk({tag, "_ready_before_edge"}, bus.in_ready, 1'b0);
        @(negedge clk);
        chk({tag, "_ready_after_edge"}, bus.in_ready, 1'b1);
    endtask

    // Result consumer: random readiness unless a scenario pins it.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1 bus.out_ready = bp_force ? bp_val : ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", bus.out_valid, 1'b0);
                end else begin
                    cmp_e = exp_q[0];
                    // The result registers on the third edge counting the last beat's handshake edge.
                    if (!prev_ov) chk("latency", 64'(cyc), 64'(hs_q[0] + 2));
                    chk("sum", bus.sum, cmp_e[ACC_W-1:0]);
                    chk("beats", bus.beats, cmp_e[ACC_W +: CNT_W]);
                    chk("ovf", bus.ovf, cmp_e[EXP_W-1]);
                    chk("in_ready_while_result", bus.in_ready, 1'b0);
                    if (bus.out_ready) begin
                        last_sum = bus.sum;
                        last_beats = bus.beats;
                        last_ovf = bus.ovf;
                        void'(exp_q.pop_front());
                        void'(hs_q.pop_front());
                    end
                end
            end
            prev_ov = bus.out_valid && !bus.out_ready;
        end
    end

    initial begin
        logic [LW-1:0] a;
        logic [LW-1:0] b;
        logic [EXP_W-1:0] m;
        logic [ACC_W-1:0] held;
        longint total;

        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.ain = '0;
        bus.bin = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        chk("reset_state_idle", dbg_state, 2'd0);
        rst_n = 1'b1;
        #1 chk("release_ready_before_edge", bus.in_ready, 1'b0);
        @(negedge clk);
        chk("release_ready_after_edge", bus.in_ready, 1'b1);

        // Single-beat vector with known dot product
        gen_pair(3, a, b);
        chk("t1_model_dot", 64'(dot(a, b)), 70);
        send_vec(1, 3, 0);
        wait_drain();
        chk("t1_sum", last_sum, 70);
        chk("t1_beats", last_beats, 1);
        chk("t1_ovf", last_ovf, 1'b0);

        // Three unit beats with a two-cycle bubble after the first
        @(negedge clk);
        gen_pair(1, a, b);
        send_beat(a, b, 1'b0);
        chk("t2_ready_gap0", bus.in_ready, 1'b1);
        @(negedge clk);
        chk("t2_ready_gap1", bus.in_ready, 1'b1);
        @(negedge clk);
        send_beat(a, b, 1'b0);
        chk("t2_ready_before_last", bus.in_ready, 1'b1);
        send_beat(a, b, 1'b1);
        total = 3 * dot(a, b);
        chk("t2_model_total", 64'(total), 12);
        exp_q.push_back(model(total, 3));
        hs_q.push_back(beat_edge);
        wait_drain();
        chk("t2_sum", last_sum, 12);
        chk("t2_beats", last_beats, 3);

        // Five full-scale beats: wrap or clamp
        m = model(5 * 4 * 255 * 255, 5);
`ifdef MAC_SAT_EN
        chk("t3_model_sum", m[ACC_W-1:0], 1048575);
        chk("t3_model_ovf", m[EXP_W-1], 1'b1);
`else
        chk("t3_model_sum", m[ACC_W-1:0], 251924);
        chk("t3_model_ovf", m[EXP_W-1], 1'b0);
`endif
        @(negedge clk);
        send_vec(5, 2, 0);
        wait_drain();
        chk("t3_sum", last_sum, m[ACC_W-1:0]);
        chk("t3_ovf", last_ovf, m[EXP_W-1]);
        @(negedge clk);
        send_vec(1, 1, 0);
        wait_drain();
        chk("t3_next_sum", last_sum, 4);
        chk("t3_next_ovf", last_ovf, 1'b0);

        // Back-pressure: result held for six cycles
        bp_force = 1'b1;
        bp_val = 1'b0;
        @(negedge clk);
        send_vec(2, 1, 0);
        wait_valid();
        held = bus.sum;
        chk("t4_held_initial", held, 8);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            chk("t4_sum_held", bus.sum, held);
            chk("t4_valid_held", bus.out_valid, 1'b1);
            chk("t4_in_ready_low", bus.in_ready, 1'b0);
        end
        bp_val = 1'b1;
        wait_drain();
        chk("t4_valid_dropped", bus.out_valid, 1'b0);
        chk("t4_in_ready_back", bus.in_ready, 1'b1);
        bp_force = 1'b0;

        // Abort a partial vector with clr, then a fresh one-beat vector
        @(negedge clk);
        gen_pair(2, a, b);
        send_beat(a, b, 1'b0);
        send_beat(a, b, 1'b0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("t5_ready_after_clr", bus.in_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_no_result", bus.out_valid, 1'b0);
        end
        send_vec(1, 4, 0);
        wait_drain();
        chk("t5_sum", last_sum, 8);
        chk("t5_beats", last_beats, 1);

        // Beat counter saturates on a long vector
        @(negedge clk);
        send_vec(300, 1, 0);
        wait_drain();
        chk("long_sum", last_sum, 1200);
        chk("long_beats", last_beats, 255);

        // Reset mid-vector, then a clean vector
        @(negedge clk);
        gen_pair(0, a, b);
        send_beat(a, b, 1'b0);
        send_beat(a, b, 1'b0);
        pulse_reset("t6_accum");
        send_vec(3, 0, 1);
        wait_drain();

        // Reset while a result is held, then a clean vector
        bp_force = 1'b1;
        bp_val = 1'b0;
        @(negedge clk);
        send_vec(2, 0, 0);
        wait_valid();
        @(negedge clk);
        bp_force = 1'b0;
        pulse_reset("t6_hold");
        send_vec(2, 4, 0);
        wait_drain();
        chk("t6_clean_sum", last_sum, 16);
        chk("t6_clean_beats", last_beats, 2);

        // Random vectors, bubbles and consumer stalls
        for (int v = 0; v < 40; v++) begin
            @(negedge clk);
            send_vec($urandom_range(1, 7), (v % 2 == 0) ? 0 : 5, 2);
            if ($urandom_range(0, 3) == 0) wait_drain();
        end
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got time %0t expected completion", $time);
        $fatal(1, "bench did not complete");
    end
endmodule
